dma_cfg_regfile: RTL and testbench
==================================

Name: dma_cfg_regfile

Overview:
- Memory-mapped control/status register file for the AXI4 DMA, directly downstream of the APB subordinate.
- Consumes the registered reg_cfg_* access bus and returns reg_cfg_rdata.
- Holds the transfer descriptor (source, destination, length, burst), runs a start/busy/done state machine toward the DMA engine, and raises the interrupt.

Parameters:
APB_S_DATA_DW  32  register/data width (fixed 32 in this revision)
APB_S_ADDR_DW  32  register address width
DMA_ADDR_DW    32  AXI address width of src/dst outputs
LEN_DW         24  transfer length width, in bytes

Ports:
S_APB_PCLK      in   1                 clock
S_APB_RESET     in   1                 asynchronous reset, active-high
reg_cfg_vld     in   1                 one-cycle access qualifier (registered PSEL&PENABLE from the APB side)
reg_cfg_wr      in   1                 1 = write, 0 = read
reg_cfg_addr    in   APB_S_ADDR_DW     byte address; bits [7:2] decode, rest ignored
reg_cfg_wdata   in   APB_S_DATA_DW     write data
reg_cfg_strobe  in   APB_S_DATA_DW/8   byte enables
reg_cfg_rdata   out  APB_S_DATA_DW     read data
dma_src_addr    out  DMA_ADDR_DW       descriptor source
dma_dst_addr    out  DMA_ADDR_DW       descriptor destination
dma_len         out  LEN_DW            descriptor length (bytes)
dma_burst_len   out  8                 AXI AxLEN
dma_start       out  1                 one-cycle start pulse
dma_abort       out  1                 one-cycle abort pulse
dma_done        in   1                 engine completion pulse
dma_err         in   1                 engine error pulse (valid with dma_done or alone)
dma_irq         out  1                 level interrupt

Behaviour:
- Register map (offset): 0x00 CTRL; 0x04 STATUS; 0x08 SRC; 0x0C DST; 0x10 LEN; 0x14 BURST; 0x18 DONE_CNT.
- CTRL: bit0 START (W1, self-clearing, reads 0); bit1 IRQ_EN (RW); bit2 ABORT (W1, reads 0).
- STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); bit2 ERR (sticky, W1C).
- Write: takes effect on the clock edge where reg_cfg_vld=1 and reg_cfg_wr=1. Each byte lane is updated only if its strobe bit is 1. LEN and SRC/DST upper bits beyond their parameter width are dropped.
- SRC, DST, LEN, BURST writes are ignored while BUSY=1 (descriptor frozen).
- Read: reg_cfg_rdata is combinational from reg_cfg_addr, independent of vld. Unmapped offsets read 0; writes to unmapped offsets have no effect. No error response.
- FSM states:
  - IDLE -> BUSY: on a START write when LEN!=0. dma_start pulses on the next cycle (registered, 1-cycle latency from the write edge).
  - START with LEN==0 stays IDLE, sets DONE, no dma_start.
  - START while BUSY is ignored.
  - BUSY -> IDLE: on dma_done. Sets DONE; sets ERR if dma_err.
  - dma_err alone while BUSY -> IDLE, sets ERR only.
  - ABORT write while BUSY -> dma_abort pulse next cycle, FSM to ABORTING. ABORTING -> IDLE on dma_done, setting ERR and not DONE.
  - ABORT in IDLE has no effect.
- BUSY reads 1 in BUSY and ABORTING.
- Simultaneous W1C write and set event on the same cycle: set wins.
- dma_irq = IRQ_EN & (DONE | ERR), registered (1-cycle latency after the flag).
- dma_done / dma_err in IDLE are ignored.
- Reset values: all registers 0, FSM IDLE, dma_start=dma_abort=dma_irq=0, all descriptor outputs 0.
- Reset mid-transfer returns to IDLE immediately without an abort pulse.

Optional Feature:
- Macro DMA_CFG_DONE_CNT_EN.
- Defined: DONE_CNT at 0x18 is a 32-bit counter that increments on each successful completion (DONE set without ERR), wraps 0xFFFFFFFF->0, and is cleared by any write.
- Undefined: no counter logic; 0x18 reads 0 and writes are ignored.

Test Plan:
- Write SRC=0x1000_0000, DST=0x2000_0000, LEN=0x100, BURST=0x0F, strobe 0xF -> outputs match, readback matches; write strobe 0x1 data 0xFFFFFFFF to SRC -> SRC=0x1000_00FF.
- Write CTRL=0x3 -> dma_start high exactly one cycle after the write edge, STATUS=0x1; pulse dma_done -> STATUS=0x2, dma_irq=1 one cycle later; write STATUS=0x2 -> STATUS=0, dma_irq=0.
- While BUSY, write LEN=0x40 and CTRL=0x1 -> LEN stays 0x100, no second dma_start.
- LEN=0, write CTRL=0x1 -> no dma_start, STATUS=0x2.
- BUSY, write CTRL=0x4 -> dma_abort one-cycle pulse, STATUS.BUSY=1 until dma_done, then STATUS=0x4; pulse dma_err alone on a fresh run -> STATUS=0x4.
- DMA_CFG_DONE_CNT_EN defined: 3 successful runs -> 0x18 reads 3; write 0x18 -> reads 0. Undefined -> 0x18 always 0.

Source files
------------

// File: rtl/dma_cfg_regfile_if.sv
// Register-access bus between the APB subordinate (master side) and the DMA
// configuration register file (slave side).
interface dma_cfg_regfile_if #(
    parameter int APB_S_DATA_DW = 32,
    parameter int APB_S_ADDR_DW = 32
);
    logic                       vld;
    logic                       wr;
    logic [APB_S_ADDR_DW-1:0]   addr;
    logic [APB_S_DATA_DW-1:0]   wdata;
    logic [APB_S_DATA_DW/8-1:0] strobe;
    logic [APB_S_DATA_DW-1:0]   rdata;

    modport master (output vld, wr, addr, wdata, strobe, input rdata);
    modport slave  (input vld, wr, addr, wdata, strobe, output rdata);
endinterface

// File: rtl/dma_cfg_regfile.sv
// Control/status register file for the AXI4 DMA: descriptor, start/busy/done FSM, interrupt.
// Optional DONE_CNT completion counter at 0x18 is built when DMA_CFG_DONE_CNT_EN is defined.
module dma_cfg_regfile #(
    parameter int APB_S_DATA_DW = 32,
    parameter int APB_S_ADDR_DW = 32,
    parameter int DMA_ADDR_DW   = 32,
    parameter int LEN_DW        = 24
) (
    input  logic                   S_APB_PCLK,
    input  logic                   S_APB_RESET,
    dma_cfg_regfile_if.slave       reg_cfg,
    output logic [DMA_ADDR_DW-1:0] dma_src_addr,
    output logic [DMA_ADDR_DW-1:0] dma_dst_addr,
    output logic [LEN_DW-1:0]      dma_len,
    output logic [7:0]             dma_burst_len,
    output logic                   dma_start,
    output logic                   dma_abort,
    input  logic                   dma_done,
    input  logic                   dma_err,
    output logic                   dma_irq
);

    localparam int DW = APB_S_DATA_DW;
    localparam int NB = APB_S_DATA_DW / 8;

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_SRC    = 6'h02;
    localparam logic [5:0] OFF_DST    = 6'h03;
    localparam logic [5:0] OFF_LEN    = 6'h04;
    localparam logic [5:0] OFF_BURST  = 6'h05;
    localparam logic [5:0] OFF_CNT    = 6'h06;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_ABORTING = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DMA_ADDR_DW-1:0] src_q, dst_q;
    logic [LEN_DW-1:0]      len_q;
    logic [7:0]             burst_q;
    logic                   irq_en_q, done_q, err_q;
    logic                   start_q, abort_q, irq_q;
    logic                   start_d, abort_d, set_done, set_err;

    logic [5:0]             offset;
    logic                   wr_en, wr_ctrl_b0, start_wr, abort_wr, clr_done, clr_err;
    logic                   busy, desc_wr;
    logic [DW-1:0]          rd_val, merged;
    logic                   addr_unused;

    // Only bits [7:2] decode; the rest are aliases.
    assign offset      = reg_cfg.addr[7:2];
    assign addr_unused = ^{reg_cfg.addr[APB_S_ADDR_DW-1:8], reg_cfg.addr[1:0]};

    assign wr_en      = reg_cfg.vld & reg_cfg.wr;
    assign wr_ctrl_b0 = wr_en & (offset == OFF_CTRL) & reg_cfg.strobe[0];
    assign start_wr   = wr_ctrl_b0 & reg_cfg.wdata[0];
    assign abort_wr   = wr_ctrl_b0 & reg_cfg.wdata[2];
    assign clr_done   = wr_en & (offset == OFF_STATUS) & reg_cfg.strobe[0] & reg_cfg.wdata[1];
    assign clr_err    = wr_en & (offset == OFF_STATUS) & reg_cfg.strobe[0] & reg_cfg.wdata[2];

    assign busy    = (state_q != ST_IDLE);
    assign desc_wr = wr_en & ~busy;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [NB-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

`ifdef DMA_CFG_DONE_CNT_EN
    logic [31:0] done_cnt_q;

    always_ff @(posedge S_APB_PCLK or posedge S_APB_RESET) begin
        if (S_APB_RESET) begin
            done_cnt_q <= '0;
        end else if (wr_en && offset == OFF_CNT) begin
            done_cnt_q <= '0;
        end else if (set_done && !set_err) begin
            done_cnt_q <= done_cnt_q + 32'd1;
        end
    end
`endif

    // The read mux also supplies the old value for strobe merging on writes.
    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_val = '0;
        unique case (offset)
            OFF_CTRL:   rd_val[1] = irq_en_q;
            OFF_STATUS: rd_val[2:0] = {err_q, done_q, busy};
            OFF_SRC:    rd_val = DW'(src_q);
            OFF_DST:    rd_val = DW'(dst_q);
            OFF_LEN:    rd_val = DW'(len_q);
            OFF_BURST:  rd_val = DW'(burst_q);
`ifdef DMA_CFG_DONE_CNT_EN
            OFF_CNT:    rd_val = DW'(done_cnt_q);
`endif
            default:    rd_val = '0;
        endcase
    end

    assign reg_cfg.rdata = rd_val;
    assign merged        = merge_bytes(rd_val, reg_cfg.wdata, reg_cfg.strobe);

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_wr) begin
                    if (len_q != '0) begin
                        state_d = ST_BUSY;
                        start_d = 1'b1;
                    end else begin
                        set_done = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (dma_done) begin
                    state_d  = ST_IDLE;
                    set_done = 1'b1;
                    set_err  = dma_err;
                end else if (dma_err) begin
                    state_d = ST_IDLE;
                    set_err = 1'b1;
                end else if (abort_wr) begin
                    state_d = ST_ABORTING;
                    abort_d = 1'b1;
                end
            end
            ST_ABORTING: begin
                if (dma_done) begin
                    state_d = ST_IDLE;
                    set_err = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge S_APB_PCLK or posedge S_APB_RESET) begin
        if (S_APB_RESET) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            abort_q <= abort_d;
            irq_q   <= irq_en_q & (done_q | err_q);
            // A set event on the same edge as a W1C keeps the flag.
            done_q  <= set_done | (done_q & ~clr_done);
            err_q   <= set_err  | (err_q  & ~clr_err);
            if (wr_ctrl_b0) irq_en_q <= reg_cfg.wdata[1];
            if (desc_wr) begin
                unique case (offset)
                    OFF_SRC:   src_q   <= merged[DMA_ADDR_DW-1:0];
                    OFF_DST:   dst_q   <= merged[DMA_ADDR_DW-1:0];
                    OFF_LEN:   len_q   <= merged[LEN_DW-1:0];
                    OFF_BURST: burst_q <= merged[7:0];
                    default:   ;
                endcase
            end
        end
    end

    assign dma_src_addr  = src_q;
    assign dma_dst_addr  = dst_q;
    assign dma_len       = len_q;
    assign dma_burst_len = burst_q;
    assign dma_start     = start_q;
    assign dma_abort     = abort_q;
    assign dma_irq       = irq_q;

endmodule

// File: tb/tb_dma_cfg_regfile.sv
// Directed bench for dma_cfg_regfile; DONE_CNT expectations follow DMA_CFG_DONE_CNT_EN.
module tb_dma_cfg_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] src_addr, dst_addr;
    logic [23:0] len;
    logic [7:0]  burst_len;
    logic        start, abort, done, err, irq;
    int          tests_run    = 0;
    int          tests_failed = 0;

    dma_cfg_regfile_if bus ();

    dma_cfg_regfile dut (
        .S_APB_PCLK    (clk),
        .S_APB_RESET   (rst),
        .reg_cfg       (bus),
        .dma_src_addr  (src_addr),
        .dma_dst_addr  (dst_addr),
        .dma_len       (len),
        .dma_burst_len (burst_len),
        .dma_start     (start),
        .dma_abort     (abort),
        .dma_done      (done),
        .dma_err       (err),
        .dma_irq       (irq)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge after the write edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.vld = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d; bus.strobe = s;
        @(negedge clk);
        bus.vld = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic pulse(input logic d, input logic e);
        @(negedge clk);
        done = d; err = e;
        @(negedge clk);
        done = 1'b0; err = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({start, abort, irq} !== 3'b000) begin tests_failed++; $display("FAIL reset_pulses: got %b expected 000", {start, abort, irq}); end
        tests_run++;
        if ({src_addr, dst_addr, len, burst_len} !== '0) begin tests_failed++; $display("FAIL reset_desc: got %h expected 0", {src_addr, dst_addr, len, burst_len}); end
        rd(32'h04, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %h expected 0", v); end
        rst = 1'b0;
    endtask

    task automatic test_descriptor;
        logic [31:0] v;
        wr(32'h08, 32'h1000_0000, 4'hF);
        wr(32'h0C, 32'h2000_0000, 4'hF);
        wr(32'h10, 32'hAB00_0100, 4'hF);
        wr(32'h14, 32'h0000_000F, 4'hF);
        tests_run++;
        if (src_addr !== 32'h1000_0000 || dst_addr !== 32'h2000_0000) begin tests_failed++; $display("FAIL desc_addr: got %h/%h expected 10000000/20000000", src_addr, dst_addr); end
        tests_run++;
        if (len !== 24'h000100 || burst_len !== 8'h0F) begin tests_failed++; $display("FAIL desc_len: got %h/%h expected 000100/0f", len, burst_len); end
        rd(32'h10, v); tests_run++;
        if (v !== 32'h0000_0100) begin tests_failed++; $display("FAIL len_readback: got %h expected 00000100", v); end
        rd(32'h0C, v); tests_run++;
        if (v !== 32'h2000_0000) begin tests_failed++; $display("FAIL dst_readback: got %h expected 20000000", v); end
        wr(32'h08, 32'hFFFF_FFFF, 4'h1);
        rd(32'h08, v); tests_run++;
        if (v !== 32'h1000_00FF || src_addr !== 32'h1000_00FF) begin tests_failed++; $display("FAIL src_strobe: got %h/%h expected 100000ff", v, src_addr); end
    endtask

    task automatic test_start_done;
        logic [31:0] v;
        wr(32'h00, 32'h3, 4'hF);
        rd(32'h04, v); tests_run++;
        if (start !== 1'b1 || v !== 32'h1) begin tests_failed++; $display("FAIL start_pulse: got start=%b status=%h expected 1/1", start, v); end
        rd(32'h00, v); tests_run++;
        if (v !== 32'h2) begin tests_failed++; $display("FAIL ctrl_readback: got %h expected 2", v); end
        @(negedge clk); tests_run++;
        if (start !== 1'b0) begin tests_failed++; $display("FAIL start_one_cycle: got %b expected 0", start); end
        pulse(1'b1, 1'b0);
        rd(32'h04, v); tests_run++;
        if (v !== 32'h2 || irq !== 1'b0) begin tests_failed++; $display("FAIL done_status: got status=%h irq=%b expected 2/0", v, irq); end
        @(negedge clk); tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_set: got %b expected 1", irq); end
        wr(32'h04, 32'h2, 4'hF);
        rd(32'h04, v);
        @(negedge clk); tests_run++;
        if (v !== 32'h0 || irq !== 1'b0) begin tests_failed++; $display("FAIL w1c_done: got status=%h irq=%b expected 0/0", v, irq); end
        pulse(1'b1, 1'b1);
        rd(32'h04, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL idle_done_ignored: got %h expected 0", v); end
    endtask

    task automatic test_busy_freeze;
        logic [31:0] v;
        logic        seen;
        wr(32'h00, 32'h1, 4'hF);
        wr(32'h10, 32'h40, 4'hF);
        seen = 1'b0;
        @(negedge clk);
        bus.vld = 1'b1; bus.wr = 1'b1; bus.addr = 32'h00; bus.wdata = 32'h1; bus.strobe = 4'hF;
        @(negedge clk);
        bus.vld = 1'b0; bus.wr = 1'b0;
        seen = start;
        @(negedge clk);
        seen = seen | start;
        tests_run++;
        if (len !== 24'h000100) begin tests_failed++; $display("FAIL len_frozen: got %h expected 000100", len); end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL no_restart: got %b expected 0", seen); end
        pulse(1'b1, 1'b0);
        wr(32'h04, 32'h6, 4'hF);
    endtask

    task automatic test_zero_len;
        logic [31:0] v;
        wr(32'h10, 32'h0, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        rd(32'h04, v); tests_run++;
        if (start !== 1'b0 || v !== 32'h2) begin tests_failed++; $display("FAIL zero_len: got start=%b status=%h expected 0/2", start, v); end
        wr(32'h04, 32'h2, 4'hF);
        wr(32'h10, 32'h100, 4'hF);
    endtask

    task automatic test_abort;
        logic [31:0] v;
        wr(32'h00, 32'h1, 4'hF);
        wr(32'h00, 32'h4, 4'hF);
        rd(32'h04, v); tests_run++;
        if (abort !== 1'b1 || v !== 32'h1) begin tests_failed++; $display("FAIL abort_pulse: got abort=%b status=%h expected 1/1", abort, v); end
        @(negedge clk);
        rd(32'h04, v); tests_run++;
        if (abort !== 1'b0 || v !== 32'h1) begin tests_failed++; $display("FAIL aborting_busy: got abort=%b status=%h expected 0/1", abort, v); end
        pulse(1'b1, 1'b0);
        rd(32'h04, v); tests_run++;
        if (v !== 32'h4) begin tests_failed++; $display("FAIL abort_done: got %h expected 4", v); end
        wr(32'h04, 32'h4, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        pulse(1'b0, 1'b1);
        rd(32'h04, v); tests_run++;
        if (v !== 32'h4) begin tests_failed++; $display("FAIL err_alone: got %h expected 4", v); end
        wr(32'h04, 32'h4, 4'hF);
        wr(32'h00, 32'h4, 4'hF);
        rd(32'h04, v); tests_run++;
        if (abort !== 1'b0 || v !== 32'h0) begin tests_failed++; $display("FAIL idle_abort: got abort=%b status=%h expected 0/0", abort, v); end
    endtask

    task automatic test_set_wins;
        logic [31:0] v;
        wr(32'h00, 32'h1, 4'hF);
        @(negedge clk);
        bus.vld = 1'b1; bus.wr = 1'b1; bus.addr = 32'h04; bus.wdata = 32'h2; bus.strobe = 4'hF;
        done = 1'b1;
        @(negedge clk);
        bus.vld = 1'b0; bus.wr = 1'b0; done = 1'b0;
        rd(32'h04, v); tests_run++;
        if (v !== 32'h2) begin tests_failed++; $display("FAIL set_wins: got %h expected 2", v); end
        wr(32'h04, 32'h2, 4'hF);
    endtask

    task automatic test_done_cnt;
        logic [31:0] v;
        wr(32'h18, 32'h5, 4'hF);
        for (int i = 0; i < 3; i++) begin
            wr(32'h00, 32'h1, 4'hF);
            pulse(1'b1, 1'b0);
        end
        rd(32'h18, v); tests_run++;
`ifdef DMA_CFG_DONE_CNT_EN
        if (v !== 32'h3) begin tests_failed++; $display("FAIL done_cnt: got %h expected 3", v); end
`else
        if (v !== 32'h0) begin tests_failed++; $display("FAIL done_cnt_off: got %h expected 0", v); end
`endif
        wr(32'h18, 32'h0, 4'hF);
        rd(32'h18, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL done_cnt_clear: got %h expected 0", v); end
        wr(32'h04, 32'h6, 4'hF);
    endtask

    task automatic test_decode;
        logic [31:0] v;
        wr(32'h1C, 32'hDEAD_BEEF, 4'hF);
        rd(32'h1C, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL unmapped: got %h expected 0", v); end
        rd(32'h0000_0108, v); tests_run++;
        if (v !== 32'h1000_00FF) begin tests_failed++; $display("FAIL alias_src: got %h expected 100000ff", v); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(32'h00, 32'h1, 4'hF);
        #2 rst = 1'b1;
        rd(32'h04, v); tests_run++;
        if (v !== 32'h0 || start !== 1'b0 || abort !== 1'b0) begin tests_failed++; $display("FAIL reset_mid: got status=%h start=%b abort=%b expected 0/0/0", v, start, abort); end
        @(negedge clk); tests_run++;
        if (abort !== 1'b0 || src_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mid_desc: got abort=%b src=%h expected 0/0", abort, src_addr); end
        rst = 1'b0;
    endtask

    initial begin
        bus.vld = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0; bus.strobe = '0;
        done = 1'b0; err = 1'b0;
        test_reset();
        test_descriptor();
        test_start_done();
        test_busy_freeze();
        test_zero_len();
        test_abort();
        test_set_wins();
        test_done_cnt();
        test_decode();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
